// File: rtl/cpu_pkg.sv
// Shared widths and FSM encoding for the register-file access arbiter.
package cpu_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned ADDR_W = 3;
    localparam int unsigned NREQ   = 2;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ISSUE   = 3'd1,
        WAIT_RD = 3'd2,
        CAPTURE = 3'd3,
        DONE    = 3'd4
    } state_t;

endpackage

// File: rtl/reg_access_if.sv
// Requester-side handshake bundle: one request/command lane per requester plus shared read results.
interface reg_access_if #(
    parameter int unsigned DATA_W = cpu_pkg::DATA_W,
    parameter int unsigned ADDR_W = cpu_pkg::ADDR_W
);
    import cpu_pkg::*;

    logic [NREQ-1:0]             req;
    logic [NREQ-1:0]             wr;
    logic [NREQ-1:0][ADDR_W-1:0] addr_a;
    logic [NREQ-1:0][ADDR_W-1:0] addr_b;
    logic [NREQ-1:0][DATA_W-1:0] wdata;
    logic [NREQ-1:0]             gnt;
    logic [NREQ-1:0]             done;
    logic [DATA_W-1:0]           rdata_a;
    logic [DATA_W-1:0]           rdata_b;

    modport master (
        output req, wr, addr_a, addr_b, wdata,
        input  gnt, done, rdata_a, rdata_b
    );

    modport slave (
        input  req, wr, addr_a, addr_b, wdata,
        output gnt, done, rdata_a, rdata_b
    );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin selector: on a tie the requester that did not win last time gets the grant.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] grant_c
);

    always_comb begin
        grant_c = 2'b00;
        case (req)
            2'b01:   grant_c = 2'b01;
            2'b10:   grant_c = 2'b10;
            2'b11:   grant_c = last ? 2'b01 : 2'b10;
            default: grant_c = 2'b00;
        endcase
    end

endmodule

// File: rtl/reg_access_arbiter.sv
// Serializes register-file accesses from two requesters; one access in flight at a time.
module reg_access_arbiter #(
    parameter int unsigned DATA_W = cpu_pkg::DATA_W,
    parameter int unsigned ADDR_W = cpu_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    reg_access_if.slave       bus,
    output logic              rf_load,
    output logic [ADDR_W-1:0] rf_addr,
    output logic [DATA_W-1:0] rf_data,
    output logic [ADDR_W-1:0] rf_addr_op1,
    output logic [ADDR_W-1:0] rf_addr_op2,
    input  logic [DATA_W-1:0] rf_out_op1,
    input  logic [DATA_W-1:0] rf_out_op2
);
    import cpu_pkg::*;

    state_t            state;
    logic              last_winner;
    logic              winner;
    logic              wr_q;
    logic [ADDR_W-1:0] addr_a_q;
    logic [ADDR_W-1:0] addr_b_q;
    logic [DATA_W-1:0] wdata_q;
    logic [1:0]        grant_c;

    rr_arb2 u_rr_arb2 (
        .req     (bus.req),
        .last    (last_winner),
        .grant_c (grant_c)
    );

    // Arbitration FSM; every output is a register updated here.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            last_winner <= 1'b1;
            winner      <= 1'b0;
            wr_q        <= 1'b0;
            addr_a_q    <= '0;
            addr_b_q    <= '0;
            wdata_q     <= '0;
            bus.gnt     <= '0;
            bus.done    <= '0;
            bus.rdata_a <= '0;
            bus.rdata_b <= '0;
            rf_load     <= 1'b0;
            rf_addr     <= '0;
            rf_data     <= '0;
            rf_addr_op1 <= '0;
            rf_addr_op2 <= '0;
        end else begin
            bus.gnt  <= '0;
            bus.done <= '0;
            rf_load  <= 1'b0;
            case (state)
                IDLE: begin
                    // The cycle showing done still sees the finished requester's req; skip it.
                    if ((|bus.req) && !(|bus.done)) begin
                        bus.gnt     <= grant_c;
                        winner      <= grant_c[1];
                        last_winner <= grant_c[1];
                        wr_q        <= bus.wr[grant_c[1]];
                        addr_a_q    <= bus.addr_a[grant_c[1]];
                        addr_b_q    <= bus.addr_b[grant_c[1]];
                        wdata_q     <= bus.wdata[grant_c[1]];
                        state       <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (wr_q) begin
                        rf_load <= 1'b1;
                        rf_addr <= addr_a_q;
                        rf_data <= wdata_q;
                        state   <= DONE;
                    end else begin
                        rf_addr_op1 <= addr_a_q;
                        rf_addr_op2 <= addr_b_q;
                        state       <= WAIT_RD;
                    end
                end
                WAIT_RD: begin
                    state <= CAPTURE;
                end
                CAPTURE: begin
                    bus.rdata_a <= rf_out_op1;
                    bus.rdata_b <= rf_out_op2;
                    state       <= DONE;
                end
                DONE: begin
                    bus.done <= winner ? 2'b10 : 2'b01;
                    state    <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reg_access_arbiter.sv
// Directed bench for reg_access_arbiter with a behavioural register file attached.
module tb_reg_access_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        rf_init;
    logic        rf_load;
    logic [2:0]  rf_addr;
    logic [15:0] rf_data;
    logic [2:0]  rf_addr_op1;
    logic [2:0]  rf_addr_op2;
    logic [15:0] rf_out_op1;
    logic [15:0] rf_out_op2;
    logic [15:0] regs [8];

    int n_cmp  = 0;
    int n_fail = 0;

    reg_access_if #(.DATA_W(16), .ADDR_W(3)) bus ();

    reg_access_arbiter #(.DATA_W(16), .ADDR_W(3)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .rf_load     (rf_load),
        .rf_addr     (rf_addr),
        .rf_data     (rf_data),
        .rf_addr_op1 (rf_addr_op1),
        .rf_addr_op2 (rf_addr_op2),
        .rf_out_op1  (rf_out_op1),
        .rf_out_op2  (rf_out_op2)
    );

    always #5 clk = ~clk;

    // Register file: synchronous write, read data one cycle after the address is sampled.
    always_ff @(posedge clk) begin
        if (rf_init) begin
            for (int i = 0; i < 8; i++) regs[i] <= 16'(100 * i);
            regs[0] <= 16'd10;
            regs[7] <= 16'd5000;
        end else if (rf_load) begin
            regs[rf_addr] <= rf_data;
        end
        rf_out_op1 <= regs[rf_addr_op1];
        rf_out_op2 <= regs[rf_addr_op2];
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        bus.req    = '0;
        bus.wr     = '0;
        bus.addr_a = '0;
        bus.addr_b = '0;
        bus.wdata  = '0;
    endtask

    task automatic apply_reset();
        clear_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Issue one access and wait (bounded) for its completion; no checking here.
    task automatic do_access(input bit idx, input bit w, input logic [2:0] a, input logic [2:0] b,
                             input logic [15:0] d, output logic [1:0] gv, output int lat,
                             output logic [1:0] dv);
        bit g;
        bus.req[idx]    = 1'b1;
        bus.wr[idx]     = w;
        bus.addr_a[idx] = a;
        bus.addr_b[idx] = b;
        bus.wdata[idx]  = d;
        g  = 1'b0;
        gv = 2'b00;
        for (int n = 0; n < 12 && !g; n++) begin
            tick();
            if (bus.gnt != 2'b00) begin g = 1'b1; gv = bus.gnt; end
        end
        bus.req[idx] = 1'b0;
        lat = -1;
        dv  = 2'b00;
        for (int n = 1; n <= 12 && g && lat < 0; n++) begin
            tick();
            if (bus.done != 2'b00) begin lat = n; dv = bus.done; end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        tick();
        n_cmp++;
        if (bus.gnt !== 2'b00 || bus.done !== 2'b00 || rf_load !== 1'b0) begin
            $display("FAIL reset_ctrl: gnt=%b done=%b rf_load=%b, required 00 00 0", bus.gnt, bus.done, rf_load);
            n_fail++;
        end
        n_cmp++;
        if (rf_addr !== 3'd0 || rf_data !== 16'd0 || rf_addr_op1 !== 3'd0 || rf_addr_op2 !== 3'd0 ||
            bus.rdata_a !== 16'd0 || bus.rdata_b !== 16'd0) begin
            $display("FAIL reset_data: rf_addr=%0d rf_data=%h op1=%0d op2=%0d ra=%h rb=%h, required all 0",
                     rf_addr, rf_data, rf_addr_op1, rf_addr_op2, bus.rdata_a, bus.rdata_b);
            n_fail++;
        end
        rst = 1'b0;
        tick();
        n_cmp++;
        if (bus.gnt !== 2'b00) begin
            $display("FAIL idle_no_req: gnt=%b, required 00", bus.gnt);
            n_fail++;
        end
    endtask

    task automatic test_write();
        bit seen;
        bus.req[0]    = 1'b1;
        bus.wr[0]     = 1'b1;
        bus.addr_a[0] = 3'd3;
        bus.wdata[0]  = 16'h1234;
        seen = 1'b0;
        for (int n = 0; n < 10 && !seen; n++) begin
            tick();
            if (bus.gnt != 2'b00) seen = 1'b1;
        end
        n_cmp++;
        if (bus.gnt !== 2'b01) begin
            $display("FAIL write_gnt: gnt=%b, required 01", bus.gnt);
            n_fail++;
        end
        bus.req[0] = 1'b0;
        tick();
        n_cmp++;
        if (rf_load !== 1'b1 || rf_addr !== 3'd3 || rf_data !== 16'h1234 || bus.done !== 2'b00) begin
            $display("FAIL write_issue: rf_load=%b rf_addr=%0d rf_data=%h done=%b, required 1 3 1234 00",
                     rf_load, rf_addr, rf_data, bus.done);
            n_fail++;
        end
        tick();
        n_cmp++;
        if (bus.done !== 2'b01 || rf_load !== 1'b0) begin
            $display("FAIL write_done: done=%b rf_load=%b, required 01 0", bus.done, rf_load);
            n_fail++;
        end
        n_cmp++;
        if (regs[3] !== 16'h1234) begin
            $display("FAIL write_reg3: reg3=%h, required 1234", regs[3]);
            n_fail++;
        end
        tick();
        n_cmp++;
        if (bus.done !== 2'b00 || rf_addr !== 3'd3 || rf_data !== 16'h1234) begin
            $display("FAIL write_hold: done=%b rf_addr=%0d rf_data=%h, required 00 3 1234",
                     bus.done, rf_addr, rf_data);
            n_fail++;
        end
    endtask

    task automatic test_read();
        logic [1:0] gv, dv;
        int lat;
        do_access(1'b1, 1'b0, 3'd0, 3'd7, 16'h0000, gv, lat, dv);
        n_cmp++;
        if (gv !== 2'b10 || dv !== 2'b10 || lat !== 4) begin
            $display("FAIL read_timing: gnt=%b done=%b latency=%0d, required 10 10 4", gv, dv, lat);
            n_fail++;
        end
        n_cmp++;
        if (bus.rdata_a !== 16'd10 || bus.rdata_b !== 16'd5000) begin
            $display("FAIL read_data: rdata_a=%0d rdata_b=%0d, required 10 5000", bus.rdata_a, bus.rdata_b);
            n_fail++;
        end
    endtask

    task automatic test_contention();
        logic [1:0] order [4];
        int ng;
        bit multi;
        apply_reset();
        bus.req       = 2'b11;
        bus.wr        = 2'b11;
        bus.addr_a[0] = 3'd1;
        bus.addr_a[1] = 3'd2;
        bus.wdata[0]  = 16'h00AA;
        bus.wdata[1]  = 16'h00BB;
        ng    = 0;
        multi = 1'b0;
        for (int n = 0; n < 40 && ng < 4; n++) begin
            tick();
            if (bus.gnt == 2'b11 || bus.done == 2'b11) multi = 1'b1;
            if (bus.gnt != 2'b00) begin order[ng] = bus.gnt; ng++; end
        end
        clear_inputs();
        n_cmp++;
        if (ng !== 4 || multi) begin
            $display("FAIL contend_count: grants=%0d double=%b, required 4 0", ng, multi);
            n_fail++;
        end
        for (int i = 0; i < ng; i++) begin
            n_cmp++;
            if (order[i] !== ((i % 2 == 0) ? 2'b01 : 2'b10)) begin
                $display("FAIL contend_order%0d: gnt=%b, required %b", i, order[i],
                         (i % 2 == 0) ? 2'b01 : 2'b10);
                n_fail++;
            end
        end
        for (int n = 0; n < 6; n++) tick();
    endtask

    task automatic test_back_to_back();
        logic [1:0] gv, dv;
        int lat;
        do_access(1'b0, 1'b1, 3'd5, 3'd0, 16'hBEEF, gv, lat, dv);
        n_cmp++;
        if (dv !== 2'b01 || lat !== 2) begin
            $display("FAIL hazard_wr: done=%b latency=%0d, required 01 2", dv, lat);
            n_fail++;
        end
        do_access(1'b0, 1'b0, 3'd5, 3'd7, 16'h0000, gv, lat, dv);
        n_cmp++;
        if (dv !== 2'b01 || bus.rdata_a !== 16'hBEEF || bus.rdata_b !== 16'd5000) begin
            $display("FAIL hazard_rd: done=%b rdata_a=%h rdata_b=%0d, required 01 beef 5000",
                     dv, bus.rdata_a, bus.rdata_b);
            n_fail++;
        end
    endtask

    task automatic test_reset_wait_rd();
        bit seen, any_done;
        bus.req[0]    = 1'b1;
        bus.wr[0]     = 1'b0;
        bus.addr_a[0] = 3'd3;
        bus.addr_b[0] = 3'd4;
        seen = 1'b0;
        for (int n = 0; n < 10 && !seen; n++) begin
            tick();
            if (bus.gnt != 2'b00) seen = 1'b1;
        end
        bus.req[0] = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        n_cmp++;
        if (bus.gnt !== 2'b00 || bus.done !== 2'b00 || rf_load !== 1'b0 || rf_addr !== 3'd0 ||
            rf_data !== 16'd0 || rf_addr_op1 !== 3'd0 || rf_addr_op2 !== 3'd0 ||
            bus.rdata_a !== 16'd0 || bus.rdata_b !== 16'd0) begin
            $display("FAIL rst_wait_outs: gnt=%b done=%b load=%b addr=%0d data=%h op1=%0d op2=%0d ra=%h rb=%h, required all 0",
                     bus.gnt, bus.done, rf_load, rf_addr, rf_data, rf_addr_op1, rf_addr_op2,
                     bus.rdata_a, bus.rdata_b);
            n_fail++;
        end
        rst = 1'b0;
        any_done = 1'b0;
        for (int n = 0; n < 6; n++) begin
            tick();
            if (bus.done != 2'b00) any_done = 1'b1;
        end
        n_cmp++;
        if (any_done) begin
            $display("FAIL rst_wait_nodone: done pulse seen=1, required 0");
            n_fail++;
        end
        bus.req = 2'b11;
        bus.wr  = 2'b00;
        seen = 1'b0;
        for (int n = 0; n < 10 && !seen; n++) begin
            tick();
            if (bus.gnt != 2'b00) seen = 1'b1;
        end
        clear_inputs();
        n_cmp++;
        if (bus.gnt !== 2'b01) begin
            $display("FAIL rst_wait_tie: gnt=%b, required 01", bus.gnt);
            n_fail++;
        end
        for (int n = 0; n < 8; n++) tick();
    endtask

    task automatic test_reset_issue();
        bit seen;
        bus.req[1]    = 1'b1;
        bus.wr[1]     = 1'b1;
        bus.addr_a[1] = 3'd6;
        bus.wdata[1]  = 16'h5A5A;
        seen = 1'b0;
        for (int n = 0; n < 10 && !seen; n++) begin
            tick();
            if (bus.gnt != 2'b00) seen = 1'b1;
        end
        bus.req[1] = 1'b0;
        rst = 1'b1;
        tick();
        n_cmp++;
        if (rf_load !== 1'b0 || bus.done !== 2'b00 || regs[6] !== 16'd600) begin
            $display("FAIL rst_issue: rf_load=%b done=%b reg6=%0d, required 0 00 600", rf_load, bus.done, regs[6]);
            n_fail++;
        end
        rst = 1'b0;
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation time limit reached, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        rst     = 1'b1;
        rf_init = 1'b1;
        clear_inputs();
        tick();
        tick();
        rf_init = 1'b0;
        test_reset();
        test_write();
        test_read();
        test_contention();
        test_back_to_back();
        test_reset_wait_rd();
        test_reset_issue();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
